// File: rtl/e_mdu_pkg.sv
// Shared types, op encodings and result helper for the E-stage multiply/divide unit.
package e_mdu_pkg;

   localparam int unsigned XLEN            = 32;
   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MTHI  = 4'd5,
      MDU_MTLO  = 4'd6,
      MDU_MFHI  = 4'd7,
      MDU_MFLO  = 4'd8
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

   // Shadow result: wr is cleared for a divide by zero so HI/LO keep their value.
   typedef struct packed {
      logic            wr;
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
   } mdu_res_t;

   function automatic logic is_arith(input mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   // Full result of an arithmetic op; divisor is forced to 1 when zero to keep the divider defined.
   function automatic mdu_res_t compute(input mdu_op_e op, input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
      mdu_res_t          r;
      logic [2*XLEN-1:0] p;
      logic [XLEN-1:0]   bs, abs_a, abs_b, qm, rm;
      r     = '0;
      p     = '0;
      bs    = (b == '0) ? XLEN'(1) : b;
      abs_a = a[XLEN-1]  ? -a  : a;
      abs_b = bs[XLEN-1] ? -bs : bs;
      qm    = abs_a / abs_b;
      rm    = abs_a % abs_b;
      case (op)
         MDU_MULT: begin
            p = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
            r = '{wr: 1'b1, hi: p[2*XLEN-1:XLEN], lo: p[XLEN-1:0]};
         end
         MDU_MULTU: begin
            p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
            r = '{wr: 1'b1, hi: p[2*XLEN-1:XLEN], lo: p[XLEN-1:0]};
         end
         MDU_DIV: begin
            r.wr = (b != '0);
            r.lo = (a[XLEN-1] ^ b[XLEN-1]) ? -qm : qm;
            r.hi = a[XLEN-1] ? -rm : rm;
         end
         MDU_DIVU: begin
            r.wr = (b != '0);
            r.lo = a / bs;
            r.hi = a % bs;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage <-> MDU signal bundle.
interface e_mdu_if;
   import e_mdu_pkg::*;

   logic            start;
   mdu_op_e         mdu_op;
   logic [XLEN-1:0] A;
   logic [XLEN-1:0] B;
   logic            busy;
   logic [XLEN-1:0] HI_out;
   logic [XLEN-1:0] LO_out;
   logic [XLEN-1:0] MDUout;

   modport master (output start, mdu_op, A, B, input busy, HI_out, LO_out, MDUout);
   modport slave  (input start, mdu_op, A, B, output busy, HI_out, LO_out, MDUout);

endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input logic    clk,
   input logic    rst,
   e_mdu_if.slave mdu
);

   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   mdu_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            launch, commit;
   mdu_res_t        res_t;
   logic [XLEN-1:0] hi_q, lo_q;

   // Next state: launch an arith op when idle, commit when the countdown reaches 1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      launch  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mdu.start && is_arith(mdu.mdu_op)) begin
               launch  = 1'b1;
               state_d = ST_BUSY;
               cnt_d   = ((mdu.mdu_op == MDU_MULT) || (mdu.mdu_op == MDU_MULTU))
                         ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end
         end
         ST_BUSY: begin
            if (cnt_q == CNT_W'(1)) begin
               commit  = 1'b1;
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Latency counter.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // Shadow result captured at launch, held until commit.
   always_ff @(posedge clk) begin
      if (rst)         res_t <= '0;
      else if (launch) res_t <= compute(mdu.mdu_op, mdu.A, mdu.B);
   end

   // Architectural HI/LO: commit from shadow, or MTHI/MTLO while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (commit) begin
         if (res_t.wr) begin
            hi_q <= res_t.hi;
            lo_q <= res_t.lo;
         end
      end else if (state_q == ST_IDLE) begin
         if (mdu.mdu_op == MDU_MTHI) hi_q <= mdu.A;
         if (mdu.mdu_op == MDU_MTLO) lo_q <= mdu.A;
      end
   end

   assign mdu.busy   = (state_q == ST_BUSY);
   assign mdu.HI_out = hi_q;
   assign mdu.LO_out = lo_q;
   assign mdu.MDUout = (mdu.mdu_op == MDU_MFHI) ? hi_q :
                       (mdu.mdu_op == MDU_MFLO) ? lo_q : '0;

endmodule
